// File: rtl/sat_engine_pkg.sv
// Shared SAT-engine definitions: the collector FSM encoding and the 2-bit learnt-literal codes.
package sat_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_EMIT = 2'd2
  } state_e;

  // Per-variable learnt literal codes
  localparam logic [1:0] LIT_ABSENT  = 2'b00;
  localparam logic [1:0] LIT_POS     = 2'b01;
  localparam logic [1:0] LIT_NEG     = 2'b10;
  localparam logic [1:0] LIT_ILLEGAL = 2'b11;

  // A slot contributes to the clause only with a proper polarity code
  function automatic logic lit_present(input logic [1:0] lit);
    return (lit == LIT_POS) || (lit == LIT_NEG);
  endfunction

endpackage

// File: rtl/learnt_clause_collect_lvl_top2.sv
// Running top-two distinct decision levels: folds one literal level into
// (max, highest-strictly-below-max). sec_vld says a lower level has been seen at all,
// which is what separates "sec is really 0" from "nothing below max yet".
module lvl_top2_update #(
  parameter int WIDTH_LVL = 16
) (
  input  logic                 any_i,
  input  logic [WIDTH_LVL-1:0] max_i,
  input  logic [WIDTH_LVL-1:0] sec_i,
  input  logic                 sec_vld_i,
  input  logic [WIDTH_LVL-1:0] lvl_i,
  output logic [WIDTH_LVL-1:0] max_o,
  output logic [WIDTH_LVL-1:0] sec_o,
  output logic                 sec_vld_o
);

  // Fold lvl_i into the running pair; the first literal just seeds max
  always_comb begin
    max_o     = max_i;
    sec_o     = sec_i;
    sec_vld_o = sec_vld_i;
    if (!any_i) begin
      max_o     = lvl_i;
      sec_o     = '0;
      sec_vld_o = 1'b0;
    end else if (lvl_i > max_i) begin
      // old max is now the best level strictly below the new max
      max_o     = lvl_i;
      sec_o     = max_i;
      sec_vld_o = 1'b1;
    end else if ((lvl_i < max_i) && (!sec_vld_i || (lvl_i > sec_i))) begin
      sec_o     = lvl_i;
      sec_vld_o = 1'b1;
    end
  end

endmodule

// File: rtl/learnt_clause_collect.sv
// Learnt-clause collector: snapshots the learnt literals and their levels on start_i,
// walks one slot per cycle to get length / backtrack level / unsat / error, then
// presents the clause on a valid/ready handshake. All outputs come from flops.
module learnt_clause_collect
  import sat_engine_pkg::*;
#(
  parameter int NUM_VARS    = 8,
  parameter int WIDTH_LVL   = 16,
  parameter int WIDTH_C_LEN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [2*NUM_VARS-1:0]         learnt_lits_i,
  input  logic [NUM_VARS*WIDTH_LVL-1:0] lvls_i,
  input  logic [WIDTH_LVL-1:0]          cur_lvl_i,
  output logic                          clause_valid_o,
  input  logic                          clause_ready_i,
  output logic [2*NUM_VARS-1:0]         clause_lits_o,
  output logic [WIDTH_C_LEN-1:0]        clause_len_o,
  output logic [WIDTH_LVL-1:0]          bkt_lvl_o,
  output logic                          unsat_o,
  output logic                          err_o,
  output logic                          busy_o
);

  localparam int                     IDX_W    = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_VARS - 1);
  localparam logic [WIDTH_C_LEN-1:0] LEN_MAX  = '1;

  state_e state_q, state_d;

  // Snapshot taken on start
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [2*NUM_VARS-1:0]         lits_q, lits_d;
  logic [NUM_VARS*WIDTH_LVL-1:0] lvls_q, lvls_d;
  logic [WIDTH_LVL-1:0]          cur_lvl_q, cur_lvl_d;

  // Scan accumulators
  logic [WIDTH_C_LEN-1:0] len_q, len_d;
  logic                   any_q, any_d;
  logic [WIDTH_LVL-1:0]   max_q, max_d;
  logic [WIDTH_LVL-1:0]   sec_q, sec_d;
  logic                   sec_vld_q, sec_vld_d;
  logic                   err_q, err_d;

  // Registered clause outputs
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [2*NUM_VARS-1:0]  out_lits_q, out_lits_d;
  logic [WIDTH_C_LEN-1:0] out_len_q, out_len_d;
  logic [WIDTH_LVL-1:0]   bkt_q, bkt_d;
  logic                   unsat_q, unsat_d;
  logic                   out_err_q, out_err_d;

  // Current slot view
  logic [1:0]           slot_lit [NUM_VARS];
  logic [WIDTH_LVL-1:0] slot_lvl [NUM_VARS];
  logic [1:0]           cur_lit;
  logic [WIDTH_LVL-1:0] cur_slot_lvl;
  logic [WIDTH_LVL-1:0] upd_max, upd_sec;
  logic                 upd_sec_vld;
  logic                 scan_last;
  logic [WIDTH_LVL-1:0] bkt_fin;
  logic                 unsat_fin;

  // The current decision level is kept with the snapshot for observability but
  // does not enter the backtrack computation.
  logic unused_cur_lvl;
  assign unused_cur_lvl = ^cur_lvl_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VARS; gi++) begin : g_slot
      assign slot_lit[gi] = lits_q[2*gi +: 2];
      assign slot_lvl[gi] = lvls_q[gi*WIDTH_LVL +: WIDTH_LVL];
    end
  endgenerate

  assign cur_lit      = slot_lit[idx_q];
  assign cur_slot_lvl = slot_lvl[idx_q];
  assign scan_last    = (state_q == ST_SCAN) && (idx_q == LAST_IDX);

  lvl_top2_update #(
    .WIDTH_LVL(WIDTH_LVL)
  ) u_lvl_top2 (
    .any_i    (any_q),
    .max_i    (max_q),
    .sec_i    (sec_q),
    .sec_vld_i(sec_vld_q),
    .lvl_i    (cur_slot_lvl),
    .max_o    (upd_max),
    .sec_o    (upd_sec),
    .sec_vld_o(upd_sec_vld)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: start only counts in IDLE, scan runs exactly NUM_VARS cycles
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_i)            state_d = ST_SCAN;
      ST_SCAN: if (idx_q == LAST_IDX)  state_d = ST_EMIT;
      ST_EMIT: if (clause_ready_i)     state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, looked ahead one state so the flops line up with the state
  always_comb begin
    valid_d = (state_d == ST_EMIT);
    busy_d  = (state_d != ST_IDLE);
  end

  // Snapshot capture and per-slot accumulation
  always_comb begin
    idx_d     = idx_q;
    lits_d    = lits_q;
    lvls_d    = lvls_q;
    cur_lvl_d = cur_lvl_q;
    len_d     = len_q;
    any_d     = any_q;
    max_d     = max_q;
    sec_d     = sec_q;
    sec_vld_d = sec_vld_q;
    err_d     = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          lits_d    = learnt_lits_i;
          lvls_d    = lvls_i;
          cur_lvl_d = cur_lvl_i;
          idx_d     = '0;
          len_d     = '0;
          any_d     = 1'b0;
          max_d     = '0;
          sec_d     = '0;
          sec_vld_d = 1'b0;
          err_d     = 1'b0;
        end
      end
      ST_SCAN: begin
        if (lit_present(cur_lit)) begin
          if (len_q == LEN_MAX) err_d = 1'b1;
          else                  len_d = len_q + WIDTH_C_LEN'(1);
          any_d     = 1'b1;
          max_d     = upd_max;
          sec_d     = upd_sec;
          sec_vld_d = upd_sec_vld;
        end else if (cur_lit == LIT_ILLEGAL) begin
          err_d = 1'b1;
        end
        if (idx_q != LAST_IDX) idx_d = idx_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  // Clause results from the fully accumulated values (including the last slot)
  always_comb begin
    if (sec_vld_d)            bkt_fin = sec_d;
    else if (max_d == '0)     bkt_fin = '0;
    else                      bkt_fin = max_d - WIDTH_LVL'(1);
    unsat_fin = (len_d == '0) || (max_d == '0);
  end

  // Clause output registers load once, as the scan finishes, and then hold
  always_comb begin
    out_lits_d = out_lits_q;
    out_len_d  = out_len_q;
    bkt_d      = bkt_q;
    unsat_d    = unsat_q;
    out_err_d  = out_err_q;
    if (scan_last) begin
      out_lits_d = lits_q;
      out_len_d  = len_d;
      bkt_d      = bkt_fin;
      unsat_d    = unsat_fin;
      out_err_d  = err_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= '0;
      lits_q     <= '0;
      lvls_q     <= '0;
      cur_lvl_q  <= '0;
      len_q      <= '0;
      any_q      <= 1'b0;
      max_q      <= '0;
      sec_q      <= '0;
      sec_vld_q  <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      out_lits_q <= '0;
      out_len_q  <= '0;
      bkt_q      <= '0;
      unsat_q    <= 1'b0;
      out_err_q  <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      lits_q     <= lits_d;
      lvls_q     <= lvls_d;
      cur_lvl_q  <= cur_lvl_d;
      len_q      <= len_d;
      any_q      <= any_d;
      max_q      <= max_d;
      sec_q      <= sec_d;
      sec_vld_q  <= sec_vld_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      out_lits_q <= out_lits_d;
      out_len_q  <= out_len_d;
      bkt_q      <= bkt_d;
      unsat_q    <= unsat_d;
      out_err_q  <= out_err_d;
    end
  end

  assign clause_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign clause_lits_o  = out_lits_q;
  assign clause_len_o   = out_len_q;
  assign bkt_lvl_o      = bkt_q;
  assign unsat_o        = unsat_q;
  assign err_o          = out_err_q;

endmodule
